sqrt_result_buffer: RTL and testbench
=====================================

SQRT_RESULT_BUFFER -- requirements
Module: sqrt_result_buffer

Interface
REQ-001 SHALL have parameter exp_width, default 8, exponent field width of the result word.
REQ-002 SHALL have parameter mant_width, default 24, significand width including the hidden bit; result word width is exp_width+mant_width.
REQ-003 SHALL have parameter DEPTH, default 4, number of entries (power of two, 2..16).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_l  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port issue  input  1  pulse: the sqrt unit accepted an operand this cycle (its in_valid && in_ready).
REQ-007 SHALL have port cancel  input  1  the sqrt unit is being cancelled; in-flight operations are lost.
REQ-008 SHALL have port res_valid  input  1  single-cycle result strobe from the sqrt unit.
REQ-009 SHALL have port res_data  input  exp_width+mant_width  rounded result word.
REQ-010 SHALL have port res_exc  input  5  exception flags {NV,DZ,OF,UF,NX}.
REQ-011 SHALL have port issue_allow  output  1  upstream may assert issue this cycle.
REQ-012 SHALL have port out_valid  output  1  head entry is available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-014 SHALL have port out_data  output  exp_width+mant_width  head result word.
REQ-015 SHALL have port out_exc  output  5  head exception flags.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  stored entries.
REQ-017 SHALL have port overflow  output  1  sticky: a result arrived with no free entry.
REQ-018 SHALL have port fflags  output  5  sticky accumulated exception flags.
REQ-019 SHALL have port fflags_clr  input  1  clear fflags and overflow.

Function
REQ-020 SHALL store {res_data,res_exc} at the tail when res_valid=1 and count<DEPTH; out_valid first asserts the cycle after the write (1-cycle latency, no bypass).
REQ-021 SHALL pop the head when out_valid && out_ready; out_data/out_exc SHALL hold stable while out_valid && !out_ready.
REQ-022 SHALL accept simultaneous push and pop at any count, including full (count unchanged).
REQ-023 SHALL keep an in-flight counter: +1 on issue, -1 on res_valid, unchanged when both occur; cancel SHALL clear it to 0 (issue in the same cycle as cancel is ignored).
REQ-024 SHALL drive issue_allow = (count + inflight) < DEPTH, combinationally from registered state only.
REQ-025 SHALL drop a result arriving when full with no pop in that cycle, leaving entries unchanged and setting overflow.
REQ-026 SHALL ignore res_valid when inflight=0 for the in-flight counter (no underflow) but still store the result.
REQ-027 SHALL wrap read/write pointers modulo DEPTH.
REQ-028 SHALL keep stored entries on cancel.
REQ-029 SHALL drive out_data and out_exc to 0 when out_valid=0.

Reset
REQ-030 SHALL on rst_l=0 asynchronously set out_valid=0, out_data=0, out_exc=0, count=0, inflight=0, pointers=0, overflow=0, fflags=0; issue_allow=1 after reset.
REQ-031 SHALL discard all entries on reset asserted mid-operation; the first result after release is stored at entry 0.

Configuration
REQ-032 SHALL, with SQRT_RESBUF_FFLAGS_EN defined, OR res_exc of every stored result into fflags; fflags_clr clears first, then same-cycle new flags are ORed in (new flags win).
REQ-033 SHALL, without SQRT_RESBUF_FFLAGS_EN, tie fflags to 0; fflags_clr then clears only overflow.

Structure
REQ-034 SHALL take from shared package fpu_pkg: EXC_W=5, flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0, and the typedef of the {data,exc} entry struct.
REQ-035 SHALL use no sub-module other than the codebase rvdffe register cell for entries, pointers and counters.

Verification
REQ-036 Single op: issue, then res_valid with 0x40000000/exc 0x00 -> out_valid next cycle, out_data=0x40000000, count=1, fflags=0x00.
REQ-037 Invalid: res_data 0x7FC00000/exc 0x10 -> out_exc=0x10, fflags=0x10; fflags_clr -> fflags=0x00.
REQ-038 Fill DEPTH=4 with out_ready=0 -> issue_allow=0 when count+inflight=4; fifth res_valid -> overflow=1, entries unchanged.
REQ-039 Full with simultaneous push and pop over 8 cycles -> count stays 4, order preserved across pointer wrap.
REQ-040 issue then cancel before res_valid -> inflight=0, issue_allow=1, stored entries intact.
REQ-041 rst_l low with 3 entries stored -> out_valid=0, count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU exception-flag layout and the {data,exc} result entry.
package fpu_pkg;
   localparam int EXC_W = 5;
   localparam int NV    = 4;
   localparam int DZ    = 3;
   localparam int OF    = 2;
   localparam int UF    = 1;
   localparam int NX    = 0;
   localparam int RES_W = 32;
   typedef struct packed {
      logic [RES_W-1:0] data;
      logic [EXC_W-1:0] exc;
   } res_entry_t;
endpackage

// File: rtl/rvdffe.sv
// rvdffe: enabled register cell with asynchronous active-low reset to zero.
module rvdffe #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_din,
   output logic [WIDTH-1:0] o_dout
);
   always_ff @(posedge clk or negedge rst_l)
      if (!rst_l) o_dout <= '0;
      else if (i_en) o_dout <= i_din;
endmodule

// File: rtl/sqrt_result_buffer.sv
// sqrt_result_buffer: result FIFO behind the sqrt unit with in-flight credit tracking.
// Define SQRT_RESBUF_FFLAGS_EN to accumulate sticky exception flags into fflags.
module sqrt_result_buffer
   import fpu_pkg::*;
#(
   parameter int exp_width  = 8,
   parameter int mant_width = 24,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst_l,
   input  logic                          issue,
   input  logic                          cancel,
   input  logic                          res_valid,
   input  logic [exp_width+mant_width-1:0] res_data,
   input  logic [EXC_W-1:0]              res_exc,
   output logic                          issue_allow,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [exp_width+mant_width-1:0] out_data,
   output logic [EXC_W-1:0]              out_exc,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow,
   output logic [EXC_W-1:0]              fflags,
   input  logic                          fflags_clr
);
   localparam int DW = exp_width + mant_width;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count, r_inflight, w_count_nxt, w_inflight_nxt;
   logic          r_overflow, w_overflow_nxt;
   logic          w_full, w_pop, w_push, w_drop;
   res_entry_t    r_mem [DEPTH];
   res_entry_t    w_wr, w_head;
   always_comb begin
      w_full         = r_count == CW'(DEPTH);
      w_pop          = out_valid && out_ready;
      w_push         = res_valid && (!w_full || w_pop);
      w_drop         = res_valid && !w_push;
      w_count_nxt    = r_count + CW'(w_push) - CW'(w_pop);
      // A result with nothing in flight is still stored but must not underflow the credit count
      w_inflight_nxt = cancel ? '0
                     : r_inflight + CW'(issue) - CW'(res_valid && r_inflight != '0);
      w_overflow_nxt = (r_overflow && !fflags_clr) || w_drop;
      w_wr           = '{data: RES_W'(res_data), exc: res_exc};
      w_head         = r_mem[r_rptr];
   end
   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      rvdffe #(.WIDTH($bits(res_entry_t))) u_ent (
         .clk(clk), .rst_l(rst_l), .i_en(w_push && r_wptr == AW'(i)),
         .i_din(w_wr), .o_dout(r_mem[i]));
   end
   rvdffe #(.WIDTH(AW)) u_wptr (.clk(clk), .rst_l(rst_l), .i_en(w_push),
      .i_din(r_wptr + AW'(1)), .o_dout(r_wptr));
   rvdffe #(.WIDTH(AW)) u_rptr (.clk(clk), .rst_l(rst_l), .i_en(w_pop),
      .i_din(r_rptr + AW'(1)), .o_dout(r_rptr));
   rvdffe #(.WIDTH(CW)) u_count (.clk(clk), .rst_l(rst_l), .i_en(1'b1),
      .i_din(w_count_nxt), .o_dout(r_count));
   rvdffe #(.WIDTH(CW)) u_inflight (.clk(clk), .rst_l(rst_l), .i_en(1'b1),
      .i_din(w_inflight_nxt), .o_dout(r_inflight));
   rvdffe #(.WIDTH(1)) u_ovf (.clk(clk), .rst_l(rst_l), .i_en(1'b1),
      .i_din(w_overflow_nxt), .o_dout(r_overflow));
`ifdef SQRT_RESBUF_FFLAGS_EN
   logic [EXC_W-1:0] r_fflags;
   // Clear applies before same-cycle flags are merged, so new flags survive a clear
   rvdffe #(.WIDTH(EXC_W)) u_fflags (.clk(clk), .rst_l(rst_l), .i_en(1'b1),
      .i_din((fflags_clr ? '0 : r_fflags) | (w_push ? res_exc : '0)), .o_dout(r_fflags));
   assign fflags = r_fflags;
`else
   assign fflags = '0;
`endif
   assign issue_allow = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
   assign out_valid   = r_count != '0;
   assign out_data    = out_valid ? DW'(w_head.data) : '0;
   assign out_exc     = out_valid ? w_head.exc : '0;
   assign count       = r_count;
   assign overflow    = r_overflow;
endmodule

// File: tb/tb_sqrt_result_buffer.sv
// tb_sqrt_result_buffer: directed and random checks against a queue-based reference model.
module tb_sqrt_result_buffer;
   localparam int DEPTH = 4;
`ifdef SQRT_RESBUF_FFLAGS_EN
   localparam bit FEN = 1'b1;
`else
   localparam bit FEN = 1'b0;
`endif
   logic        clk = 1'b0, rst_l = 1'b0;
   logic        issue = 1'b0, cancel = 1'b0, res_valid = 1'b0, out_ready = 1'b0, fflags_clr = 1'b0;
   logic [31:0] res_data = '0;
   logic [4:0]  res_exc = '0;
   logic        issue_allow, out_valid, overflow;
   logic [31:0] out_data;
   logic [4:0]  out_exc, fflags;
   logic [2:0]  count;
   int          n_vec = 0, n_err = 0;
   logic [36:0] q[$];
   int          m_inflight = 0;
   logic        m_ovf = 1'b0;
   logic [4:0]  m_ff = '0;

   always #5 clk = ~clk;

   sqrt_result_buffer #(.exp_width(8), .mant_width(24), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_l(rst_l), .issue(issue), .cancel(cancel), .res_valid(res_valid),
      .res_data(res_data), .res_exc(res_exc), .issue_allow(issue_allow), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc), .count(count),
      .overflow(overflow), .fflags(fflags), .fflags_clr(fflags_clr));

   function automatic logic [31:0] m_data();
      return q.size() != 0 ? q[0][36:5] : 32'h0;
   endfunction
   function automatic logic [4:0] m_exc();
      return q.size() != 0 ? q[0][4:0] : 5'h0;
   endfunction
   function automatic logic m_allow();
      return (q.size() + m_inflight) < DEPTH;
   endfunction

   task automatic drive(input logic i, input logic c, input logic rv, input logic [31:0] d,
                        input logic [4:0] e, input logic rdy, input logic clr);
      bit pop, push;
      issue = i; cancel = c; res_valid = rv; res_data = d; res_exc = e;
      out_ready = rdy; fflags_clr = clr;
      @(posedge clk);
      pop  = q.size() != 0 && rdy;
      push = rv && (q.size() < DEPTH || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back({d, e});
      m_inflight = c ? 0 : m_inflight + int'(i) - int'(rv && m_inflight > 0);
      m_ovf = (m_ovf && !clr) || (rv && !push);
      m_ff = FEN ? ((clr ? 5'h0 : m_ff) | (push ? e : 5'h0)) : 5'h0;
      @(negedge clk);
      issue = 0; cancel = 0; res_valid = 0; out_ready = 0; fflags_clr = 0;
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 1; k++) drive(0, 0, 0, 0, 0, 1, 1);
   endtask

   task automatic test_reset();
      #2;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if (issue_allow !== 1'b1) begin n_err++; $display("FAIL reset_allow: got %b want 1", issue_allow); end
      n_vec++; if (overflow !== 1'b0 || fflags !== 5'h0) begin n_err++; $display("FAIL reset_sticky: ovf %b ff %h want 0/00", overflow, fflags); end
      n_vec++; if (out_data !== 32'h0 || out_exc !== 5'h0) begin n_err++; $display("FAIL reset_data: got %h/%h want 0/0", out_data, out_exc); end
      @(negedge clk); rst_l = 1'b1;
   endtask

   task automatic test_single();
      drive(1, 0, 0, 0, 0, 0, 0);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
      drive(0, 0, 1, 32'h40000000, 5'h00, 0, 0);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
      n_vec++; if (out_data !== 32'h40000000) begin n_err++; $display("FAIL single_data: got %h want 40000000", out_data); end
      n_vec++; if (count !== 3'd1 || fflags !== 5'h00) begin n_err++; $display("FAIL single_count_ff: got %0d/%h want 1/00", count, fflags); end
      drive(0, 0, 0, 0, 0, 1, 0);
      n_vec++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin n_err++; $display("FAIL single_pop: got %b/%h want 0/0", out_valid, out_data); end
   endtask

   task automatic test_invalid();
      drive(0, 0, 1, 32'h7FC00000, 5'h10, 0, 0);
      n_vec++; if (out_exc !== 5'h10) begin n_err++; $display("FAIL nv_exc: got %h want 10", out_exc); end
      n_vec++; if (fflags !== (FEN ? 5'h10 : 5'h00)) begin n_err++; $display("FAIL nv_fflags: got %h want %h", fflags, FEN ? 5'h10 : 5'h00); end
      drive(0, 0, 1, 32'h3F800000, 5'h01, 1, 1);
      n_vec++; if (fflags !== (FEN ? 5'h01 : 5'h00)) begin n_err++; $display("FAIL clr_new_wins: got %h want %h", fflags, FEN ? 5'h01 : 5'h00); end
      n_vec++; if (out_data !== 32'h3F800000 || out_exc !== 5'h01) begin n_err++; $display("FAIL nv_next: got %h/%h want 3f800000/01", out_data, out_exc); end
      drive(0, 0, 0, 0, 0, 1, 1);
      n_vec++; if (fflags !== 5'h00 || out_valid !== 1'b0) begin n_err++; $display("FAIL nv_clr: got %h/%b want 00/0", fflags, out_valid); end
   endtask

   task automatic test_fill_overflow();
      logic [31:0] d0;
      for (int k = 0; k < DEPTH; k++) begin
         drive(1, 0, 0, 0, 0, 0, 0);
         n_vec++; if (issue_allow !== (k < DEPTH - 1)) begin n_err++; $display("FAIL fill_allow%0d: got %b want %b", k, issue_allow, k < DEPTH - 1); end
      end
      d0 = $urandom;
      drive(0, 0, 1, d0, 5'h04, 0, 0);
      for (int k = 1; k < DEPTH; k++) drive(0, 0, 1, $urandom, 5'($urandom), 0, 0);
      n_vec++; if (count !== 3'd4 || issue_allow !== 1'b0) begin n_err++; $display("FAIL full_state: got %0d/%b want 4/0", count, issue_allow); end
      drive(0, 0, 1, 32'hDEADBEEF, 5'h1F, 0, 0);
      n_vec++; if (overflow !== 1'b1 || count !== 3'd4) begin n_err++; $display("FAIL overflow: got %b/%0d want 1/4", overflow, count); end
      n_vec++; if (out_data !== d0) begin n_err++; $display("FAIL ovf_head: got %h want %h", out_data, d0); end
      drive(0, 0, 0, 0, 0, 0, 1);
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
   endtask

   task automatic test_full_pushpop();
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, $urandom, 5'($urandom), 1, 0);
         n_vec++; if (count !== 3'd4 || overflow !== 1'b0) begin n_err++; $display("FAIL pp_count%0d: got %0d/%b want 4/0", k, count, overflow); end
         n_vec++; if (out_data !== m_data() || out_exc !== m_exc()) begin n_err++; $display("FAIL pp_head%0d: got %h/%h want %h/%h", k, out_data, out_exc, m_data(), m_exc()); end
      end
      for (int k = 0; k < DEPTH; k++) begin
         n_vec++; if (out_data !== m_data()) begin n_err++; $display("FAIL pp_order%0d: got %h want %h", k, out_data, m_data()); end
         drive(0, 0, 0, 0, 0, 1, 0);
      end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_cancel();
      drive(0, 0, 1, 32'h11111111, 5'h02, 0, 0);
      drive(0, 0, 1, 32'h22222222, 5'h08, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      n_vec++; if (issue_allow !== 1'b0) begin n_err++; $display("FAIL cancel_pre: got %b want 0", issue_allow); end
      drive(1, 1, 0, 0, 0, 0, 0);
      n_vec++; if (issue_allow !== 1'b1 || count !== 3'd2) begin n_err++; $display("FAIL cancel_post: got %b/%0d want 1/2", issue_allow, count); end
      n_vec++; if (out_data !== 32'h11111111) begin n_err++; $display("FAIL cancel_keep: got %h want 11111111", out_data); end
      drive(1, 0, 0, 0, 0, 0, 0);
      n_vec++; if (issue_allow !== 1'b1) begin n_err++; $display("FAIL cancel_credit: got %b want 1", issue_allow); end
      drain();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         drive(m_allow() && $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 1, $urandom, 5'($urandom),
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
         n_vec++;
         if (out_valid !== (q.size() != 0) || count !== 3'(q.size()) || issue_allow !== m_allow() ||
             out_data !== m_data() || out_exc !== m_exc() || overflow !== m_ovf || fflags !== m_ff) begin
            n_err++;
            $display("FAIL rand%0d: got v%b c%0d a%b d%h e%h o%b f%h want v%b c%0d a%b d%h e%h o%b f%h",
                     k, out_valid, count, issue_allow, out_data, out_exc, overflow, fflags,
                     q.size() != 0, q.size(), m_allow(), m_data(), m_exc(), m_ovf, m_ff);
         end
      end
      drain();
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 3; k++) drive(0, 0, 1, 32'hA0000000 + 32'(k), 5'(k), 0, 0);
      n_vec++; if (count !== 3'd3) begin n_err++; $display("FAIL ar_pre: got %0d want 3", count); end
      #2 rst_l = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_err++; $display("FAIL ar_async: got %b/%0d want 0/0", out_valid, count); end
      n_vec++; if (issue_allow !== 1'b1 || out_data !== 32'h0) begin n_err++; $display("FAIL ar_outs: got %b/%h want 1/0", issue_allow, out_data); end
      q.delete(); m_inflight = 0; m_ovf = 1'b0; m_ff = '0;
      @(negedge clk); rst_l = 1'b1;
      drive(0, 0, 1, 32'h5A5A5A5A, 5'h03, 0, 0);
      n_vec++; if (out_data !== 32'h5A5A5A5A || count !== 3'd1) begin n_err++; $display("FAIL ar_after: got %h/%0d want 5a5a5a5a/1", out_data, count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_invalid();
      test_fill_overflow();
      test_full_pushpop();
      test_cancel();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
